// File: rtl/vespa_asm_input_rx.sv
// Receive end of the asm output path: synchronizes the gated strobe, measures pulse
// width, rejects glitches, detects a missing response and hands events over valid/ready.
module vespa_asm_input_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 2,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 8
) (
   input  logic             CELCLK,
   input  logic             CELRST,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             CELSUB,
   input  logic             i,
   input  logic             tstate,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_width,
   output logic             evt_timeout,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ARMED, PULSE, HOLD} state_t;

   localparam logic [CNT_W-1:0] WIDTH_MAX    = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MIN_W        = CNT_W'(MIN_WIDTH);

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                 si, si_d, rise;
   logic [CNT_W-1:0]     wait_cnt, wait_nxt;
   logic [CNT_W-1:0]     width, width_nxt;
   logic                 timeout_flag, timeout_nxt;
   logic                 ovf_q, ovf_set;

   // Supply/ground/substrate ties carry no logic; folded here so they are not dangling.
   logic unused_ties;
   assign unused_ties = CELV ^ CELG ^ CELSUB;

   assign si   = sync[SYNC_STAGES-1];
   assign rise = si & ~si_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which is what makes the shift chain work.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         sync <= '0;
         si_d <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], i};
         si_d <= si;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      width_nxt   = width;
      timeout_nxt = timeout_flag;
      ovf_set     = 1'b0;
      unique case (state)
         IDLE: begin
            wait_nxt = '0;
            if (tstate) state_nxt = ARMED;
         end
         ARMED: begin
            wait_nxt = wait_cnt + CNT_W'(1);
            if (!tstate) begin
               state_nxt = IDLE;
            end else if (rise) begin
               state_nxt   = PULSE;
               width_nxt   = CNT_W'(1);
               timeout_nxt = 1'b0;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               state_nxt   = HOLD;
               width_nxt   = '0;
               timeout_nxt = 1'b1;
            end
         end
         PULSE: begin
            if (si) begin
               if (width != WIDTH_MAX) width_nxt = width + CNT_W'(1);
            end else if (width >= MIN_W) begin
               state_nxt   = HOLD;
               timeout_nxt = 1'b0;
            end else begin
               // Too short: discard silently and resume waiting.
               state_nxt = tstate ? ARMED : IDLE;
               wait_nxt  = '0;
            end
         end
         HOLD: begin
            ovf_set = rise;
            if (evt_ready) begin
               state_nxt = tstate ? ARMED : IDLE;
               wait_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         width        <= '0;
         timeout_flag <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_nxt;
         width        <= width_nxt;
         timeout_flag <= timeout_nxt;
         // A dropped pulse outranks a simultaneous clear.
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign evt_valid   = (state == HOLD);
   assign busy        = (state != IDLE);
   assign evt_width   = width;
   assign evt_timeout = timeout_flag;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_vespa_asm_input_rx.sv
// Self-checking bench for vespa_asm_input_rx: directed scenarios plus a randomized run
// compared against a flag-based behavioural model of the receiver.
module tb_vespa_asm_input_rx;

   localparam int SYNC_STAGES = 2;
   localparam int MIN_WIDTH   = 2;
   localparam int TIMEOUT     = 64;
   localparam int CNT_W       = 8;
   localparam int TIMEOUT4    = 12;

   logic clk = 1'b0;
   logic rst, i, tstate, ready, ovf_clr;
   logic vdd = 1'b1, gnd = 1'b0, sub = 1'b0;
   logic evt_valid, evt_timeout, ovf, busy;
   logic [CNT_W-1:0] evt_width;

   logic i4, tstate4, ready4, ovf_clr4;
   logic valid4, timeout4, ovf4, busy4;
   logic [3:0] width4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vespa_asm_input_rx #(.SYNC_STAGES(SYNC_STAGES), .MIN_WIDTH(MIN_WIDTH),
                        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .CELCLK(clk), .CELRST(rst), .CELV(vdd), .CELG(gnd), .CELSUB(sub),
      .i(i), .tstate(tstate), .evt_valid(evt_valid), .evt_ready(ready),
      .evt_width(evt_width), .evt_timeout(evt_timeout), .ovf(ovf),
      .ovf_clr(ovf_clr), .busy(busy));

   vespa_asm_input_rx #(.SYNC_STAGES(SYNC_STAGES), .MIN_WIDTH(MIN_WIDTH),
                        .TIMEOUT(TIMEOUT4), .CNT_W(4)) dut4 (
      .CELCLK(clk), .CELRST(rst), .CELV(vdd), .CELG(gnd), .CELSUB(sub),
      .i(i4), .tstate(tstate4), .evt_valid(valid4), .evt_ready(ready4),
      .evt_width(width4), .evt_timeout(timeout4), .ovf(ovf4),
      .ovf_clr(ovf_clr4), .busy(busy4));

   // Behavioural model: what the receiver is doing, expressed as independent flags.
   bit m_armed, m_meas, m_pend, m_tout, m_ovf, m_si, m_si_d;
   int m_wait, m_width;
   bit pipe[$];

   function automatic void model_reset();
      m_armed = 0; m_meas = 0; m_pend = 0; m_tout = 0; m_ovf = 0;
      m_si = 0; m_si_d = 0; m_wait = 0; m_width = 0;
      pipe.delete();
      for (int k = 0; k < SYNC_STAGES - 1; k++) pipe.push_back(1'b0);
   endfunction

   function automatic void model_step();
      bit rose;
      bit lost;
      rose = m_si && !m_si_d;
      lost = 0;
      if (m_pend) begin
         lost = rose;
         if (ready) begin
            m_pend = 0; m_armed = tstate; m_wait = 0;
         end
      end else if (m_meas) begin
         if (m_si) begin
            m_width = (m_width + 1 > 2**CNT_W - 1) ? 2**CNT_W - 1 : m_width + 1;
         end else if (m_width >= MIN_WIDTH) begin
            m_meas = 0; m_pend = 1; m_tout = 0;
         end else begin
            m_meas = 0; m_armed = tstate; m_wait = 0;
         end
      end else if (m_armed) begin
         if (!tstate) m_armed = 0;
         else if (rose) begin
            m_meas = 1; m_width = 1;
         end else if (m_wait == TIMEOUT - 1) begin
            m_pend = 1; m_tout = 1; m_width = 0;
         end else m_wait++;
      end else if (tstate) begin
         m_armed = 1; m_wait = 0;
      end
      if (lost) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      pipe.push_back(i);
      m_si_d = m_si;
      m_si = pipe.pop_front();
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_model();
      check("valid", 32'(evt_valid), 32'(m_pend));
      check("busy", 32'(busy), 32'(m_armed || m_meas || m_pend));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (m_pend) begin
         check("width", 32'(evt_width), 32'(m_width));
         check("timeout", 32'(evt_timeout), 32'(m_tout));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(evt_valid), 0);
      check({tag, "_width"}, 32'(evt_width), 0);
      check({tag, "_timeout"}, 32'(evt_timeout), 0);
      check({tag, "_ovf"}, 32'(ovf), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int run;
      rst = 1; i = 0; tstate = 0; ready = 0; ovf_clr = 0;
      i4 = 0; tstate4 = 0; ready4 = 0; ovf_clr4 = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 0;

      // Basic pulse of 5 cycles.
      tstate = 1;
      step();
      i = 1; n = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 5) i = 0;
         if (evt_valid) begin n = k; break; end
      end
      check("pulse_latency", n, SYNC_STAGES + 6);
      check("pulse_width", 32'(evt_width), 5);
      check("pulse_timeout", 32'(evt_timeout), 0);
      ready = 1; step(); ready = 0;
      check("xfer_valid", 32'(evt_valid), 0);
      check("xfer_busy", 32'(busy), 1);

      // Single-cycle glitch, then timeout counted from the return to waiting.
      i = 1; n = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (k == 1) i = 0;
         if (evt_valid) begin n = k; break; end
      end
      check("glitch_then_timeout", n, SYNC_STAGES + 2 + TIMEOUT);
      check("glitch_to_flag", 32'(evt_timeout), 1);
      check("glitch_to_width", 32'(evt_width), 0);

      // Timeout from a fresh wait.
      ready = 1; step(); ready = 0;
      n = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (evt_valid) begin n = k; break; end
      end
      check("timeout_cycle", n, TIMEOUT);
      check("timeout_flag", 32'(evt_timeout), 1);
      check("timeout_width", 32'(evt_width), 0);
      ready = 1; step(); ready = 0;

      // Overflow: second pulse while the first event waits.
      i = 1; n = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 3) i = 0;
         if (evt_valid) begin n = k; break; end
      end
      check("ovf_first_width", 32'(evt_width), 3);
      i = 1; repeat (3) step();
      i = 0; repeat (4) step();
      check("ovf_set", 32'(ovf), 1);
      check("ovf_width_kept", 32'(evt_width), 3);
      check("ovf_valid_kept", 32'(evt_valid), 1);
      i = 1; repeat (SYNC_STAGES) step();
      ovf_clr = 1; step(); ovf_clr = 0;
      check("ovf_set_beats_clr", 32'(ovf), 1);
      i = 0; ovf_clr = 1; step(); ovf_clr = 0;
      check("ovf_cleared", 32'(ovf), 0);
      ready = 1; step(); ready = 0;

      // Asynchronous reset mid-pulse.
      i = 1; repeat (SYNC_STAGES + 3) step();
      check("pre_rst_busy", 32'(busy), 1);
      #2 rst = 1;
      #1 check_all_zero("rst_pulse");
      model_reset();
      @(negedge clk); rst = 0; i = 0;
      #1 check("rst_pulse_idle", 32'(busy), 0);

      // Asynchronous reset while an event is pending.
      step();
      i = 1; n = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 3) i = 0;
         if (evt_valid) begin n = k; break; end
      end
      check("pre_rst_valid", 32'(evt_valid), 1);
      #2 rst = 1;
      #1 check_all_zero("rst_hold");
      model_reset();
      @(negedge clk); rst = 0;
      #1 check("rst_hold_idle", 32'(busy), 0);

      // Width saturation with a 4-bit counter.
      tstate = 0;
      tstate4 = 1; step();
      i4 = 1; repeat (20) step();
      i4 = 0; n = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (valid4) begin n = k; break; end
      end
      check("sat_seen", 32'(valid4), 1);
      check("sat_width", 32'(width4), 15);
      check("sat_timeout", 32'(timeout4), 0);
      tstate4 = 0; ready4 = 1; step(); ready4 = 0;
      check("sat_xfer_valid", 32'(valid4), 0);
      check("sat_xfer_idle", 32'(busy4), 0);

      // Randomized traffic against the model.
      run = 0;
      tstate = 1;
      for (int k = 0; k < 4000; k++) begin
         if (run == 0) begin
            i = ~i;
            run = $urandom_range(1, 6);
         end
         run--;
         if ($urandom_range(0, 99) == 0) tstate = ~tstate;
         ready = ($urandom_range(0, 3) == 0);
         ovf_clr = ($urandom_range(0, 20) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vespa_asm_input_rx.md
Name: vespa_asm_input_rx

Overview:
- Receive end of the asm control-loop output path: samples the delayed, tstate-gated strobe driven by an asm output stage and converts it into a qualified synchronous event.
- Synchronizes the asynchronous strobe, measures pulse width, rejects glitches and watches for a missing response.
- Delivers each event to the loop controller over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, synchronizer depth on i (min 2)
MIN_WIDTH, 2, minimum synchronized high cycles for a valid pulse (min 1)
TIMEOUT, 64, armed cycles without a rising edge before a timeout event (min 2)
CNT_W, 8, width of the pulse-width and timeout counters (2^CNT_W > TIMEOUT)

Ports:
CELCLK  in  1  clock
CELRST  in  1  asynchronous, active-high reset
CELV  in  1  supply tie; no logic function
CELG  in  1  ground tie; no logic function
CELSUB  in  1  substrate tie; no logic function
i  in  1  asynchronous strobe from output stage
tstate  in  1  arm enable, synchronous to CELCLK
evt_valid  out  1  event pending
evt_ready  in  1  consumer accepts event
evt_width  out  CNT_W  measured pulse width in cycles, saturating
evt_timeout  out  1  event is a timeout, not a pulse
ovf  out  1  sticky: pulse lost while event pending
ovf_clr  in  1  clears ovf
busy  out  1  state != IDLE

Behaviour:
- Reset (CELRST=1, any time, including mid-pulse or with evt_valid high):
  - sync flops 0, state IDLE, counters 0.
  - evt_valid, evt_width, evt_timeout, ovf and busy all 0.
- Synchronizer: i passes through SYNC_STAGES flops to give si. Rising edge = si & ~si_d. All decisions use si.
- Latency: rising edge of i to PULSE entry is SYNC_STAGES+1 cycles.
- IDLE:
  - tstate=1 -> ARMED, wait counter cleared.
  - Edges of si are ignored.
- ARMED:
  - Wait counter increments each cycle.
  - tstate=0 -> IDLE.
  - Else rising edge -> PULSE with width=1; a rising edge has priority over timeout in the same cycle.
  - Else wait counter == TIMEOUT-1 -> HOLD with evt_timeout=1, evt_width=0.
- PULSE:
  - While si=1, width increments, saturating at 2^CNT_W-1.
  - On si=0: width >= MIN_WIDTH -> HOLD with evt_width=width, evt_timeout=0.
  - On si=0 with width < MIN_WIDTH: glitch, return to ARMED with wait counter cleared, or to IDLE if tstate=0. No event, no ovf.
  - tstate dropping during PULSE does not abort the measurement.
- HOLD:
  - evt_valid=1. evt_width and evt_timeout are held stable until the transfer.
  - Transfer on evt_valid & evt_ready; evt_valid drops the next cycle. Next state is ARMED (wait counter cleared) if tstate=1, else IDLE.
  - A rising edge while in HOLD, including the transfer cycle, is dropped and sets ovf.
- ovf: set on a dropped pulse. ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- evt_ready with evt_valid=0 has no effect.
- A pulse already high when ARMED is entered is not counted; a new rising edge is required.

Test Plan:
- Reset, tstate=1, i high 5 cycles -> evt_valid at cycle SYNC_STAGES+6 after the i rise, evt_width=5, evt_timeout=0; evt_ready=1 -> evt_valid=0 next cycle, busy=1 (ARMED).
- tstate=1, i high 1 cycle (MIN_WIDTH=2) -> no evt_valid, state back to ARMED; timeout then fires 64 cycles after the glitch.
- tstate=1, i held 0 -> evt_valid with evt_timeout=1, evt_width=0 exactly TIMEOUT cycles after ARMED entry.
- Event pending with evt_ready=0, second pulse on i -> ovf=1, original evt_width unchanged. ovf_clr=1 in the same cycle as a third pulse -> ovf stays 1.
- CELRST asserted mid-PULSE and again with evt_valid=1 -> all outputs 0 immediately (asynchronous), IDLE after release.
- CNT_W=4, pulse 20 cycles -> evt_width=15 (saturated).
